// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST response-analysis stage.
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int SIG_W = 4;

    // x^4+x+1: q3 feeds back into q0 and q1.
    localparam logic [SIG_W-1:0] SISR_FB = 4'b0011;

endpackage

// File: rtl/bist_sig_checker_sisr4.sv
// 4-bit serial-input signature register (x^4+x+1) with shift enable and synchronous clear.
module sisr4_en
    import bist_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             din_i,
    output logic [SIG_W-1:0] sig_o
);

    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clr_i) begin
            sig_d = '0;
        end else if (en_i) begin
            sig_d = {sig_q[SIG_W-2:0], din_i} ^ (sig_q[SIG_W-1] ? SISR_FB : '0);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/bist_sig_checker.sv
// Compacts one session of LEN serial response bits and compares the signature to a golden value.
module bist_sig_checker
    import bist_pkg::*;
#(
    parameter  int LEN = 16,
    localparam int CW  = $clog2(LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [SIG_W-1:0] golden,
    input  logic             din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] sig,
    output logic [CW-1:0]    bit_cnt
);

    localparam logic [CW-1:0] LAST_CNT = CW'(LEN - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [SIG_W-1:0] golden_q, golden_d;
    logic             pass_q, pass_d;
    logic             start_ok;
    logic             accept;

    // abort dominates both a new session and data acceptance.
    assign start_ok = start && !abort && (state_q == IDLE || state_q == DONE);
    assign accept   = din_valid && din_ready && !abort;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        golden_d  = golden_q;
        pass_d    = pass_q;
        if (abort) begin
            state_d = IDLE;
            pass_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_ok) begin
                        state_d   = RUN;
                        bit_cnt_d = '0;
                        golden_d  = golden;
                        pass_d    = 1'b0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        bit_cnt_d = bit_cnt_q + CW'(1);
                        if (bit_cnt_q == LAST_CNT) begin
                            state_d = CHECK;
                        end
                    end
                end
                CHECK: begin
                    pass_d  = (sig == golden_q);
                    state_d = DONE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            golden_q  <= '0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            golden_q  <= golden_d;
            pass_q    <= pass_d;
        end
    end

    sisr4_en u_sisr (
        .clk_i (clk),
        .rst_i (rst),
        .clr_i (start_ok),
        .en_i  (accept),
        .din_i (din),
        .sig_o (sig)
    );

    assign din_ready = (state_q == RUN);
    assign busy      = (state_q == RUN) || (state_q == CHECK);
    assign done      = (state_q == DONE);
    assign pass      = pass_q;
    assign bit_cnt   = bit_cnt_q;

endmodule

// File: tb/tb_bist_sig_checker.sv
// Directed bench for bist_sig_checker with LEN=4 and hand-computed signatures.
module tb_bist_sig_checker;

  localparam int LEN = 4;
  localparam int CW  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [3:0]    golden = 4'h0;
  logic          din = 1'b0;
  logic          din_valid = 1'b0;
  logic          din_ready;
  logic          busy;
  logic          done;
  logic          pass;
  logic [3:0]    sig;
  logic [CW-1:0] bit_cnt;

  int checks = 0;
  int failures = 0;
  logic [3:0] exp_q[$];

  bist_sig_checker #(.LEN(LEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .golden    (golden),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .sig       (sig),
    .bit_cnt   (bit_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // drivers: inputs change #1 after the edge, outputs sampled there too
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_session(input logic [3:0] g);
    start  = 1'b1;
    golden = g;
    step();
    start = 1'b0;
  endtask

  task automatic send_bit(input logic b, input string tag);
    logic [3:0] e;
    din       = b;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    e = exp_q.pop_front();
    check(tag, sig, e);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_sig"},   sig, 4'h0);
    check({tag, "_cnt"},   bit_cnt, 0);
    check({tag, "_done"},  done, 1'b0);
    check({tag, "_pass"},  pass, 1'b0);
    check({tag, "_busy"},  busy, 1'b0);
    check({tag, "_ready"}, din_ready, 1'b0);
  endtask

  initial begin
    #12 rst = 1'b0;
    #4;
    check_reset_vals("reset");

    // session 1: 1111, golden F
    start_session(4'hF);
    check("s1_busy", busy, 1'b1);
    check("s1_ready", din_ready, 1'b1);
    check("s1_sig0", sig, 4'h0);
    exp_q = '{4'h1, 4'h3, 4'h7, 4'hF};
    send_bit(1'b1, "s1_b1");
    check("s1_cnt1", bit_cnt, 1);
    send_bit(1'b1, "s1_b2");
    send_bit(1'b1, "s1_b3");
    send_bit(1'b1, "s1_b4");
    check("s1_cnt4", bit_cnt, 4);
    check("s1_check_busy", busy, 1'b1);
    check("s1_check_done", done, 1'b0);
    check("s1_check_ready", din_ready, 1'b0);
    step();
    check("s1_done", done, 1'b1);
    check("s1_pass", pass, 1'b1);
    check("s1_busy_done", busy, 1'b0);

    // session 2 back-to-back: 1000, golden 8
    start_session(4'h8);
    check("s2_done_drop", done, 1'b0);
    check("s2_sig_clr", sig, 4'h0);
    check("s2_cnt_clr", bit_cnt, 0);
    check("s2_pass_clr", pass, 1'b0);
    exp_q = '{4'h1, 4'h2, 4'h4, 4'h8};
    send_bit(1'b1, "s2_b1");
    send_bit(1'b0, "s2_b2");
    send_bit(1'b0, "s2_b3");
    send_bit(1'b0, "s2_b4");
    step();
    check("s2_done", done, 1'b1);
    check("s2_pass", pass, 1'b1);

    // session 3: 1111 against golden 8 fails compare
    start_session(4'h8);
    exp_q = '{4'h1, 4'h3, 4'h7, 4'hF};
    for (int i = 0; i < 4; i++) send_bit(1'b1, "s3_b");
    step();
    check("s3_done", done, 1'b1);
    check("s3_pass", pass, 1'b0);
    check("s3_sig", sig, 4'hF);
    check("s3_cnt_hold", bit_cnt, 4);

    // session 4: gapped valid 1,0,0,1,1,0,1; start in RUN ignored
    begin
      logic [6:0] vpat;
      int exp_cnt[7];
      vpat = 7'b1011001;
      exp_cnt = '{1, 1, 1, 2, 3, 3, 4};
      start_session(4'hF);
      din = 1'b1;
      for (int i = 0; i < 7; i++) begin
        din_valid = vpat[i];
        start = (i == 1);
        golden = 4'h3;
        step();
        check("s4_cnt", bit_cnt, exp_cnt[i]);
      end
      din_valid = 1'b0;
      start = 1'b0;
      check("s4_sig", sig, 4'hF);
      step();
      check("s4_done", done, 1'b1);
      check("s4_pass", pass, 1'b1);
      check("s4_ready_done", din_ready, 1'b0);
    end

    // abort after 2 bits with simultaneous start and valid bit
    start_session(4'hF);
    exp_q = '{4'h1, 4'h3};
    send_bit(1'b1, "ab_b1");
    send_bit(1'b1, "ab_b2");
    abort = 1'b1;
    start = 1'b1;
    din = 1'b1;
    din_valid = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    din_valid = 1'b0;
    check("ab_busy", busy, 1'b0);
    check("ab_done", done, 1'b0);
    check("ab_pass", pass, 1'b0);
    check("ab_cnt_hold", bit_cnt, 2);
    check("ab_sig_hold", sig, 4'h3);
    check("ab_ready", din_ready, 1'b0);
    start_session(4'h0);
    check("ab_restart_sig", sig, 4'h0);
    check("ab_restart_cnt", bit_cnt, 0);
    exp_q = '{4'h0, 4'h0, 4'h0, 4'h0};
    for (int i = 0; i < 4; i++) send_bit(1'b0, "ab_z");
    step();
    check("ab_zero_pass", pass, 1'b1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("ab_done_drop", done, 1'b0);
    check("ab_done_pass", pass, 1'b0);

    // async reset mid-run
    start_session(4'hF);
    exp_q = '{4'h1, 4'h3};
    send_bit(1'b1, "rs_b1");
    send_bit(1'b1, "rs_b2");
    #2 rst = 1'b1;
    #1;
    check_reset_vals("rst_mid");
    #3 rst = 1'b0;
    step();
    check_reset_vals("rst_hold");
    start_session(4'hF);
    exp_q = '{4'h1, 4'h3, 4'h7, 4'hF};
    for (int i = 0; i < 4; i++) send_bit(1'b1, "rs_b");
    step();
    check("rs_done", done, 1'b1);
    check("rs_pass", pass, 1'b1);

    // golden changed during RUN is ignored
    start_session(4'hF);
    golden = 4'h0;
    exp_q = '{4'h1, 4'h3, 4'h7, 4'hF};
    for (int i = 0; i < 4; i++) send_bit(1'b1, "gl_b");
    step();
    check("gl_done", done, 1'b1);
    check("gl_pass", pass, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
